// File: rtl/arp_pkg.sv
// rtl/arp_pkg.sv - ARP field constants, offsets and parser state type shared by ARP RX/TX
package arp_pkg;

    localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IP  = 16'h0800;
    localparam logic [7:0]  ARP_HLEN      = 8'd6;
    localparam logic [7:0]  ARP_PLEN      = 8'd4;
    localparam logic [15:0] ARP_OP_REQ    = 16'd1;
    localparam logic [15:0] ARP_OP_REPLY  = 16'd2;

    localparam logic [7:0] ARP_OFF_HTYPE = 8'd0;
    localparam logic [7:0] ARP_OFF_PTYPE = 8'd2;
    localparam logic [7:0] ARP_OFF_HLEN  = 8'd4;
    localparam logic [7:0] ARP_OFF_PLEN  = 8'd5;
    localparam logic [7:0] ARP_OFF_OP    = 8'd6;
    localparam logic [7:0] ARP_OFF_SHA   = 8'd8;
    localparam logic [7:0] ARP_OFF_SPA   = 8'd14;
    localparam logic [7:0] ARP_OFF_THA   = 8'd18;
    localparam logic [7:0] ARP_OFF_TPA   = 8'd24;
    localparam logic [7:0] ARP_OFF_END   = 8'd27;
    localparam int          ARP_MIN_LEN   = 46;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } arp_rx_state_t;

    // One-byte check of the payload at a given offset; own_ip supplies the TPA bytes.
    function automatic logic arp_byte_mismatch(input logic [7:0] off, input logic [7:0] b,
                                               input logic [31:0] own_ip);
        logic m;
        m = 1'b0;
        case (off)
            ARP_OFF_HTYPE:         m = (b != ARP_HTYPE_ETH[15:8]);
            ARP_OFF_HTYPE + 8'd1:  m = (b != ARP_HTYPE_ETH[7:0]);
            ARP_OFF_PTYPE:         m = (b != ARP_PTYPE_IP[15:8]);
            ARP_OFF_PTYPE + 8'd1:  m = (b != ARP_PTYPE_IP[7:0]);
            ARP_OFF_HLEN:          m = (b != ARP_HLEN);
            ARP_OFF_PLEN:          m = (b != ARP_PLEN);
            ARP_OFF_OP:            m = (b != ARP_OP_REQ[15:8]);
            ARP_OFF_OP + 8'd1:     m = (b != ARP_OP_REQ[7:0]) && (b != ARP_OP_REPLY[7:0]);
            ARP_OFF_TPA:           m = (b != own_ip[31:24]);
            ARP_OFF_TPA + 8'd1:    m = (b != own_ip[23:16]);
            ARP_OFF_TPA + 8'd2:    m = (b != own_ip[15:8]);
            ARP_OFF_TPA + 8'd3:    m = (b != own_ip[7:0]);
            default:               m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/arp_rx_if.sv
// rtl/arp_rx_if.sv - MAC RX byte stream in, parsed ARP sender info out
interface arp_rx_if;
    logic [7:0]  i_mac_data;
    logic        i_mac_last;
    logic        i_mac_valid;
    logic [31:0] o_rx_ip;
    logic [47:0] o_rx_mac;
    logic [15:0] o_rx_op;
    logic        o_rx_valid;
    logic        o_trig_reply;

    modport master (
        output i_mac_data, i_mac_last, i_mac_valid,
        input  o_rx_ip, o_rx_mac, o_rx_op, o_rx_valid, o_trig_reply
    );

    modport slave (
        input  i_mac_data, i_mac_last, i_mac_valid,
        output o_rx_ip, o_rx_mac, o_rx_op, o_rx_valid, o_trig_reply
    );
endinterface

// File: rtl/arp_rx.sv
// rtl/arp_rx.sv - ARP receive parser: validates payload, captures sender, triggers replies
module arp_rx
    import arp_pkg::*;
#(
    parameter logic [31:0] P_SRC_IP  = {8'd192, 8'd168, 8'd10, 8'd1},
    parameter logic [7:0]  P_MAX_CNT = 8'd255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_src_ip,
    input  logic        i_src_ip_valid,
    arp_rx_if.slave     bus
);

    logic [7:0]    d_data;
    logic          d_last;
    logic          d_valid;
    logic [7:0]    cnt;
    logic [31:0]   own_ip;
    logic [31:0]   snap_ip;
    logic [15:0]   op_sh;
    logic [47:0]   sha_sh;
    logic [31:0]   spa_sh;
    arp_rx_state_t state, state_nxt;
    logic          cur_mis;
    logic          accept;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            d_data  <= '0;
            d_last  <= 1'b0;
            d_valid <= 1'b0;
        end else begin
            d_data  <= bus.i_mac_data;
            d_last  <= bus.i_mac_last & bus.i_mac_valid;
            d_valid <= bus.i_mac_valid;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            own_ip <= P_SRC_IP;
        end else if (i_src_ip_valid) begin
            own_ip <= i_src_ip;
        end
    end

    // cnt is the offset of the beat currently in d_data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (d_valid) begin
            if (d_last) begin
                cnt <= '0;
            end else if (cnt != P_MAX_CNT) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign cur_mis = arp_byte_mismatch(cnt, d_data, snap_ip);
    assign accept  = (state == ST_RECV) && d_valid && d_last &&
                     (cnt >= ARP_OFF_END) && !cur_mis;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (d_valid && !d_last) state_nxt = cur_mis ? ST_DROP : ST_RECV;
            ST_RECV: begin
                if (d_valid) begin
                    if (d_last)       state_nxt = ST_IDLE;
                    else if (cur_mis) state_nxt = ST_DROP;
                end
            end
            ST_DROP: if (d_valid && d_last) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Own IP is frozen at the first beat so a mid-frame load only affects the next frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            snap_ip <= P_SRC_IP;
            op_sh   <= '0;
            sha_sh  <= '0;
            spa_sh  <= '0;
        end else if (d_valid) begin
            if (state == ST_IDLE) snap_ip <= own_ip;
            if (cnt >= ARP_OFF_OP && cnt < ARP_OFF_SHA)  op_sh  <= {op_sh[7:0], d_data};
            if (cnt >= ARP_OFF_SHA && cnt < ARP_OFF_SPA) sha_sh <= {sha_sh[39:0], d_data};
            if (cnt >= ARP_OFF_SPA && cnt < ARP_OFF_THA) spa_sh <= {spa_sh[23:0], d_data};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_rx_ip      <= '0;
            bus.o_rx_mac     <= '0;
            bus.o_rx_op      <= '0;
            bus.o_rx_valid   <= 1'b0;
            bus.o_trig_reply <= 1'b0;
        end else begin
            bus.o_rx_valid   <= accept;
            bus.o_trig_reply <= accept && (op_sh == ARP_OP_REQ);
            if (accept) begin
                bus.o_rx_ip  <= spa_sh;
                bus.o_rx_mac <= sha_sh;
                bus.o_rx_op  <= op_sh;
            end
        end
    end

endmodule

// File: tb/tb_arp_rx.sv
// tb/tb_arp_rx.sv - randomized scoreboard bench for arp_rx against a frame-level model
module tb_arp_rx;
    import arp_pkg::*;

    localparam logic [31:0] SRC_IP = 32'hC0A80A01;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_src_ip;
    logic        i_src_ip_valid;

    arp_rx_if bus();

    arp_rx dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_src_ip       (i_src_ip),
        .i_src_ip_valid (i_src_ip_valid),
        .bus            (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          cyc;
        logic [31:0] ip;
        logic [47:0] mac;
        logic [15:0] op;
        logic        trig;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [7:0]  frm[$];
    logic [31:0] own_model;
    logic [31:0] held_ip;
    logic [47:0] held_mac;
    logic [15:0] held_op;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic build(input logic [15:0] op, input logic [47:0] sha, input logic [31:0] spa,
                         input logic [31:0] tpa, input logic [15:0] ptype, input int len);
        frm.delete();
        frm.push_back(8'h00); frm.push_back(8'h01);
        frm.push_back(ptype[15:8]); frm.push_back(ptype[7:0]);
        frm.push_back(8'd6); frm.push_back(8'd4);
        frm.push_back(op[15:8]); frm.push_back(op[7:0]);
        for (int i = 5; i >= 0; i--) frm.push_back(sha[8*i +: 8]);
        for (int i = 3; i >= 0; i--) frm.push_back(spa[8*i +: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
        for (int i = 3; i >= 0; i--) frm.push_back(tpa[8*i +: 8]);
        while (frm.size() < len) frm.push_back(8'($urandom));
        while (frm.size() > len) void'(frm.pop_back());
    endtask

    function automatic logic model_accept(input logic [31:0] own);
        logic [15:0] op;
        if (frm.size() < 28) return 1'b0;
        op = {frm[6], frm[7]};
        return ({frm[0], frm[1]} == 16'h0001) && ({frm[2], frm[3]} == 16'h0800) &&
               (frm[4] == 8'd6) && (frm[5] == 8'd4) && (op == 16'd1 || op == 16'd2) &&
               ({frm[24], frm[25], frm[26], frm[27]} == own);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk); #1;
            bus.i_mac_valid = 1'b0;
            bus.i_mac_last  = 1'b0;
            i_src_ip_valid  = 1'b0;
        end
    endtask

    task automatic send(input int gap_pct, input int rst_at, input int load_at,
                        input logic [31:0] load_val);
        logic acc;
        exp_t x;
        acc    = model_accept(own_model);
        x.ip   = {frm[14], frm[15], frm[16], frm[17]};
        x.mac  = {frm[8], frm[9], frm[10], frm[11], frm[12], frm[13]};
        x.op   = {frm[6], frm[7]};
        x.trig = (x.op == 16'd1);
        for (int i = 0; i < frm.size(); i++) begin
            if (i > 0) begin
                while ($urandom_range(0, 99) < gap_pct) begin
                    @(posedge i_clk); #1;
                    bus.i_mac_valid = 1'b0;
                    bus.i_mac_last  = 1'b0;
                    i_src_ip_valid  = 1'b0;
                end
            end
            if (i == rst_at) begin
                @(posedge i_clk); #1;
                bus.i_mac_valid = 1'b0;
                bus.i_mac_last  = 1'b0;
                i_src_ip_valid  = 1'b0;
                i_rst     = 1'b1;
                held_ip   = '0;
                held_mac  = '0;
                held_op   = '0;
                own_model = SRC_IP;
                repeat (2) @(posedge i_clk);
                #1 i_rst = 1'b0;
                return;
            end
            @(posedge i_clk); #1;
            bus.i_mac_data  = frm[i];
            bus.i_mac_valid = 1'b1;
            bus.i_mac_last  = (i == frm.size() - 1);
            i_src_ip_valid  = (i == load_at);
            if (i == load_at) begin
                i_src_ip  = load_val;
                own_model = load_val;
            end
            if (bus.i_mac_last && acc) begin
                x.cyc = cyc + 2;
                sbq.push_back(x);
            end
        end
    endtask

    always @(negedge i_clk) begin
        if (bus.o_rx_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_rx_valid", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("latency_cycle", cyc, e.cyc);
                check("rx_ip", bus.o_rx_ip, e.ip);
                check("rx_mac", bus.o_rx_mac, e.mac);
                check("rx_op", bus.o_rx_op, e.op);
                check("trig_reply", bus.o_trig_reply, e.trig);
                held_ip  = e.ip;
                held_mac = e.mac;
                held_op  = e.op;
            end
        end else begin
            check("trig_without_valid", bus.o_trig_reply, 0);
            check("outputs_held", {bus.o_rx_ip, bus.o_rx_mac, bus.o_rx_op},
                  {held_ip, held_mac, held_op});
        end
    end

    initial begin
        i_rst           = 1'b1;
        i_src_ip        = '0;
        i_src_ip_valid  = 1'b0;
        bus.i_mac_data  = '0;
        bus.i_mac_last  = 1'b0;
        bus.i_mac_valid = 1'b0;
        own_model       = SRC_IP;
        held_ip         = '0;
        held_mac        = '0;
        held_op         = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_rx_valid", bus.o_rx_valid, 0);
        check("reset_trig", bus.o_trig_reply, 0);
        check("reset_rx_ip", bus.o_rx_ip, 0);
        check("reset_rx_mac", bus.o_rx_mac, 0);
        check("reset_rx_op", bus.o_rx_op, 0);
        i_rst = 1'b0;
        idle(2);

        build(16'd1, 48'h021122334455, 32'hC0A80A07, SRC_IP, 16'h0800, 46);
        send(0, -1, -1, '0); idle(4);
        build(16'd2, 48'h021122334455, 32'hC0A80A07, SRC_IP, 16'h0800, 46);
        send(0, -1, -1, '0); idle(4);
        build(16'd1, 48'h021122334455, 32'hC0A80A07, 32'hC0A80A09, 16'h0800, 46);
        send(0, -1, -1, '0); idle(4);

        build(16'd1, 48'hAABBCCDDEEFF, 32'hC0A80A20, SRC_IP, 16'h86DD, 46);
        send(0, -1, -1, '0); idle(3);
        build(16'd1, 48'hAABBCCDDEEFF, 32'hC0A80A21, SRC_IP, 16'h0800, 20);
        send(0, -1, -1, '0); idle(3);
        build(16'd1, 48'hAABBCCDDEEFF, 32'hC0A80A22, SRC_IP, 16'h0800, 46);
        send(0, -1, -1, '0); idle(4);

        build(16'd1, 48'h0A0B0C0D0E0F, 32'hC0A80A31, SRC_IP, 16'h0800, 46);
        send(30, -1, -1, '0);
        build(16'd2, 48'h1A1B1C1D1E1F, 32'hC0A80A32, SRC_IP, 16'h0800, 46);
        send(30, -1, -1, '0); idle(4);

        build(16'd1, 48'h020000000001, 32'hC0A80A41, SRC_IP, 16'h0800, 46);
        send(0, 15, -1, '0); idle(3);
        build(16'd1, 48'h020000000002, 32'hC0A80A42, SRC_IP, 16'h0800, 46);
        send(0, -1, -1, '0); idle(4);

        build(16'd1, 48'h020000000003, 32'hC0A80A51, SRC_IP, 16'h0800, 46);
        send(0, -1, 10, 32'hC0A80A09); idle(4);
        build(16'd1, 48'h020000000004, 32'hC0A80A52, 32'hC0A80A09, 16'h0800, 46);
        send(0, -1, -1, '0); idle(4);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] op;
            logic [31:0] tpa;
            logic [15:0] ptype;
            int          len;
            int          k;
            op    = ($urandom_range(0, 9) == 0) ? 16'd3 : 16'($urandom_range(1, 2));
            tpa   = ($urandom_range(0, 3) == 0) ? $urandom : own_model;
            ptype = ($urandom_range(0, 9) == 0) ? 16'h86DD : 16'h0800;
            len   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 64)) : 46;
            build(op, {$urandom, 16'($urandom)}, $urandom, tpa, ptype, len);
            if ($urandom_range(0, 6) == 0) begin
                k = $urandom_range(0, 5);
                if (k < frm.size()) frm[k] = frm[k] ^ 8'h01;
            end
            send($urandom_range(0, 40), -1, -1, '0);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end

        idle(6);
        check("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
